// File: rtl/fp32_pkg.sv
// Shared FP32 field helpers and special-operand classification for the multiplier dispatch path.
package fp32_pkg;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   typedef struct packed {
      logic        special;
      logic [31:0] val;
   } spec_t;

   function automatic logic fp32_sign(input logic [31:0] x);
      return x[31];
   endfunction

   function automatic logic [7:0] fp32_exp(input logic [31:0] x);
      return x[30:23];
   endfunction

   function automatic logic [22:0] fp32_man(input logic [31:0] x);
      return x[22:0];
   endfunction

   // Operands the multiplier cannot handle get a fixed result; denormals are flushed to zero.
   function automatic spec_t fp32_special(input logic [31:0] a, input logic [31:0] b);
      spec_t r;
      logic  s, a_nan, b_nan, a_inf, b_inf, a_zd, b_zd;
      s     = fp32_sign(a) ^ fp32_sign(b);
      a_nan = (fp32_exp(a) == EXP_MAX) && (fp32_man(a) != '0);
      b_nan = (fp32_exp(b) == EXP_MAX) && (fp32_man(b) != '0);
      a_inf = (fp32_exp(a) == EXP_MAX) && (fp32_man(a) == '0);
      b_inf = (fp32_exp(b) == EXP_MAX) && (fp32_man(b) == '0);
      a_zd  = (fp32_exp(a) == 8'h00);
      b_zd  = (fp32_exp(b) == 8'h00);
      r.special = 1'b1;
      if (a_nan || b_nan || (a_inf && b_zd) || (b_inf && a_zd))
         r.val = QNAN;
      else if (a_inf || b_inf)
         r.val = {s, EXP_MAX, 23'h0};
      else if (a_zd || b_zd)
         r.val = {s, 31'h0};
      else begin
         r.special = 1'b0;
         r.val     = 32'h0;
      end
      return r;
   endfunction

endpackage

// File: rtl/fp32_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; storage is unreset, only pointers reset.
module fp32_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             slow_clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge slow_clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge slow_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/fp32_mul_dispatch.sv
// Feeds tagged operand pairs to the slow_clk FP32 multiplier and collects results in issue order,
// substituting fixed results for NaN/inf/zero/denormal operands.
module fp32_mul_dispatch
   import fp32_pkg::*;
#(
   parameter int TAG_W     = 4,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4,
   parameter int LATENCY   = 3
) (
   input  logic             slow_clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   input  logic [31:0]      mul_c,
   input  logic             mul_overflow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_c,
   output logic             out_overflow,
   output logic             out_special,
   output logic [TAG_W-1:0] out_tag
);
   localparam int IN_W  = 64 + TAG_W;
   localparam int OUT_W = 34 + TAG_W;
   localparam int CW    = $clog2(OUT_DEPTH) + 1;

   logic [IN_W-1:0]  in_rdata;
   logic             in_full, in_empty;
   logic [OUT_W-1:0] out_wdata, out_rdata;
   logic             out_full, out_empty;
   logic [CW-1:0]    credits;
   logic             issue, out_pop, cap;
   logic [31:0]      hd_a, hd_b;
   logic [TAG_W-1:0] hd_tag;
   spec_t            hd_spec, cap_spec;
   logic             vld_p  [LATENCY];
   logic [TAG_W-1:0] tag_p  [LATENCY];
   spec_t            spec_p [LATENCY];

   fp32_sync_fifo #(.WIDTH(IN_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .slow_clk (slow_clk),
      .rst      (rst),
      .push     (in_valid),
      .pop      (issue),
      .wdata    ({in_a, in_b, in_tag}),
      .rdata    (in_rdata),
      .full     (in_full),
      .empty    (in_empty)
   );

   assign in_ready = !in_full;
   assign {hd_a, hd_b, hd_tag} = in_rdata;
   assign hd_spec  = fp32_special(hd_a, hd_b);

   // Credits cover both the output FIFO and everything still in the delay line.
   assign issue   = !in_empty && (credits != '0);
   assign out_pop = !out_empty && out_ready;

   // Issue stage: registered operands plus the matching delay-line entry
   always_ff @(posedge slow_clk or posedge rst) begin
      if (rst) begin
         mul_a   <= '0;
         mul_b   <= '0;
         credits <= CW'(OUT_DEPTH);
         for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
      end else begin
         mul_a    <= issue ? hd_a : '0;
         mul_b    <= issue ? hd_b : '0;
         vld_p[0] <= issue;
         for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
         credits  <= credits + CW'(out_pop) - CW'(issue);
      end
   end

   always_ff @(posedge slow_clk) begin
      tag_p[0]  <= hd_tag;
      spec_p[0] <= hd_spec;
      for (int i = 1; i < LATENCY; i++) begin
         tag_p[i]  <= tag_p[i-1];
         spec_p[i] <= spec_p[i-1];
      end
   end

   // Capture stage: the multiplier product for the oldest entry is valid on this edge
   assign cap_spec  = spec_p[LATENCY-1];
   assign cap       = vld_p[LATENCY-1] && !out_full;
   assign out_wdata = {cap_spec.special ? cap_spec.val : mul_c,
                       cap_spec.special ? 1'b0 : mul_overflow,
                       cap_spec.special,
                       tag_p[LATENCY-1]};

   fp32_sync_fifo #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .slow_clk (slow_clk),
      .rst      (rst),
      .push     (cap),
      .pop      (out_pop),
      .wdata    (out_wdata),
      .rdata    (out_rdata),
      .full     (out_full),
      .empty    (out_empty)
   );

   assign out_valid = !out_empty;
   assign {out_c, out_overflow, out_special, out_tag} = out_empty ? '0 : out_rdata;

endmodule

// File: tb/tb_fp32_mul_dispatch.sv
// Directed and random bench for fp32_mul_dispatch with a behavioural multiplier stub and scoreboard.
module tb_fp32_mul_dispatch;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [31:0]      c;
      logic             ovf;
      logic             spc;
      logic [TAG_W-1:0] tag;
   } res_t;

   logic             slow_clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_a = '0, in_b = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic [31:0]      mul_a, mul_b, mul_c;
   logic             mul_overflow;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_c;
   logic             out_overflow, out_special;
   logic [TAG_W-1:0] out_tag;

   int   total = 0, bad = 0;
   int   rdy_mode = 1;
   res_t sbq[$];
   res_t popped[$];
   logic [32:0] st0 = '0, st1 = '0;

   fp32_mul_dispatch #(.TAG_W(TAG_W), .IN_DEPTH(4), .OUT_DEPTH(4), .LATENCY(3)) dut (
      .slow_clk     (slow_clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_tag       (in_tag),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_c        (mul_c),
      .mul_overflow (mul_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_c        (out_c),
      .out_overflow (out_overflow),
      .out_special  (out_special),
      .out_tag      (out_tag)
   );

   always #5 slow_clk = ~slow_clk;

   // Truncating normal x normal multiply; out-of-range exponent gives 0 with overflow set.
   function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      logic [22:0] man;
      int          e;
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
         e++;
         man = m[46:24];
      end else begin
         man = m[45:23];
      end
      if (e >= 255 || e <= 0) return {1'b1, 32'h0};
      return {1'b0, a[31] ^ b[31], e[7:0], man};
   endfunction

   // Multiplier stub: product of operands driven at edge k is presented for sampling at edge k+3.
   always @(posedge slow_clk) begin
      st0 <= fmul(mul_a, mul_b);
      st1 <= st0;
   end
   assign {mul_overflow, mul_c} = st1;

   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction
   function automatic bit is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 0);
   endfunction
   function automatic bit is_zd(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [TAG_W-1:0] t);
      res_t        r;
      logic        s;
      logic [32:0] m;
      s     = a[31] ^ b[31];
      r.tag = t;
      r.ovf = 1'b0;
      r.spc = 1'b1;
      if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zd(b)) || (is_zd(a) && is_inf(b)))
         r.c = 32'h7FC00000;
      else if (is_inf(a) || is_inf(b))
         r.c = {s, 8'hFF, 23'h0};
      else if (is_zd(a) || is_zd(b))
         r.c = {s, 31'h0};
      else begin
         m     = fmul(a, b);
         r.spc = 1'b0;
         r.ovf = m[32];
         r.c   = m[31:0];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: expected results queued on accept, compared on every output handshake.
   always @(negedge slow_clk) begin
      if (rst) begin
         sbq.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("out_valid_with_nothing_pending", 64'(out_valid), 64'd0);
            end else begin
               res_t e;
               e = sbq.pop_front();
               check("result", 64'({out_c, out_overflow, out_special, out_tag}), 64'(e));
               popped.push_back(e);
            end
         end
         if (in_valid && in_ready) sbq.push_back(ref_model(in_a, in_b, in_tag));
      end
   end

   always begin
      @(posedge slow_clk);
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic idle(input int n);
      repeat (n) @(posedge slow_clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                       input int maxw, output bit ok);
      in_a = a;
      in_b = b;
      in_tag = t;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < maxw; k++) begin
         @(negedge slow_clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge slow_clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int maxc);
      for (int k = 0; k < maxc && sbq.size() != 0; k++) idle(1);
      check("drain_pending", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   ok;
      int   lat, acc, stale;
      res_t mr;

      idle(3);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_fields", 64'({out_c, out_overflow, out_special, out_tag}), 64'd0);
      check("rst_mul_ops", {mul_a, mul_b}, 64'd0);
      rst = 1'b0;
      idle(2);

      mr = ref_model(32'h7F800000, 32'h00000000, 4'd0);
      check("model_pin_inf_zero", 64'({mr.c, mr.spc}), 64'({32'h7FC00000, 1'b1}));
      mr = ref_model(32'h7F000000, 32'h7F000000, 4'd0);
      check("model_pin_ovf", 64'({mr.c, mr.ovf, mr.spc}), 64'({32'h0, 1'b1, 1'b0}));

      // Basic product and accept-to-out_valid latency
      send(32'h40000000, 32'h40400000, 4'd5, 10, ok);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge slow_clk);
         #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check("t1_latency", 64'(lat), 64'd4);
      check("t1_out_c", 64'(out_c), 64'h40C00000);
      check("t1_tag_ovf_spc", 64'({out_tag, out_overflow, out_special}), 64'({4'd5, 1'b0, 1'b0}));
      drain(20);

      // Special operand patches
      popped.delete();
      send(32'h7F800000, 32'h00000000, 4'd1, 10, ok);
      send(32'hFF800000, 32'h40000000, 4'd2, 10, ok);
      send(32'h80000000, 32'h40400000, 4'd3, 10, ok);
      drain(30);
      check("t2_count", 64'(popped.size()), 64'd3);
      if (popped.size() >= 3) begin
         check("t2_inf_x_zero", 64'({popped[0].c, popped[0].ovf, popped[0].spc}), 64'({32'h7FC00000, 2'b01}));
         check("t2_neg_inf", 64'({popped[1].c, popped[1].ovf, popped[1].spc}), 64'({32'hFF800000, 2'b01}));
         check("t2_neg_zero", 64'({popped[2].c, popped[2].ovf, popped[2].spc}), 64'({32'h80000000, 2'b01}));
      end

      // Multiplier overflow passes through unpatched
      popped.delete();
      send(32'h7F000000, 32'h7F000000, 4'd9, 10, ok);
      drain(30);
      check("t4_count", 64'(popped.size()), 64'd1);
      if (popped.size() >= 1)
         check("t4_ovf", 64'({popped[0].c, popped[0].ovf, popped[0].spc}), 64'({32'h0, 2'b10}));

      // Backpressure: credits plus input FIFO bound accepted ops at 8
      rdy_mode = 0;
      idle(2);
      popped.delete();
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         send(32'h3F800000 + 32'(i << 20), 32'h40000000, 4'(i), 6, ok);
         if (ok) acc++;
      end
      check("t3_accepted", 64'(acc), 64'd8);
      check("t3_in_ready", 64'(in_ready), 64'd0);
      rdy_mode = 1;
      drain(60);
      check("t3_count", 64'(popped.size()), 64'd8);
      for (int i = 0; i < popped.size(); i++) check("t3_tag_order", 64'(popped[i].tag), 64'(i));

      // Random operands with random consumer stalls
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         for (int j = 0; j < 2; j++) begin
            int          r;
            logic [7:0]  e;
            logic [22:0] m;
            r = $urandom_range(0, 9);
            m = 23'($urandom);
            case (r)
               0:       e = 8'h00;
               1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = '0; end
               2:       e = 8'($urandom_range(240, 254));
               default: e = 8'($urandom_range(100, 150));
            endcase
            if (j == 0) a = {1'($urandom), e, m};
            else        b = {1'($urandom), e, m};
         end
         if ($urandom_range(0, 3) == 0) idle(1);
         send(a, b, 4'(i), 60, ok);
         if (!ok) check("t5_accept_stall", 64'(in_ready), 64'd1);
      end
      rdy_mode = 1;
      drain(100);

      // Reset with operations in flight drops them
      idle(2);
      send(32'h3F800000, 32'h40000000, 4'd1, 10, ok);
      send(32'h40000000, 32'h40000000, 4'd2, 10, ok);
      send(32'h40400000, 32'h40000000, 4'd3, 10, ok);
      idle(1);
      rst = 1'b1;
      #1;
      check("t6_out_valid", 64'(out_valid), 64'd0);
      check("t6_in_ready", 64'(in_ready), 64'd1);
      idle(2);
      rst = 1'b0;
      stale = 0;
      for (int k = 0; k < 12; k++) begin
         idle(1);
         if (out_valid) stale++;
      end
      check("t6_no_stale", 64'(stale), 64'd0);
      check("final_pending", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
